mole_hit_scorer: RTL and testbench

//  Parametrised whack-a-mole hit detector and scorer; successor to the fixed 18-bit hit logic.

---
 rtl/mole_hit_scorer.sv | 83 ++++++++
 tb/tb_mole_hit_scorer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mole_hit_scorer.sv
// mole_hit_scorer: synchronises switch lanes, classifies edges as hits/misses against lit moles,
// and keeps a clamped score with a combo multiplier and optional per-cycle miss penalty.
module mole_hit_scorer #(
    parameter int N_MOLES      = 18,
    parameter int SCORE_W      = 8,
    parameter int COMBO_W      = 3,
    parameter int COMBO_THRESH = 3,
    parameter int EDGE_MODE    = 0,
    parameter int MISS_PENALTY = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic               clear_score,
    input  logic [N_MOLES-1:0] sw_in,
    input  logic [N_MOLES-1:0] mole_on,
    output logic [N_MOLES-1:0] mole_clear,
    output logic               hit_pulse,
    output logic               miss_pulse,
    output logic [SCORE_W-1:0] score,
    output logic [COMBO_W-1:0] combo
);
    localparam int PW = $clog2(2 * N_MOLES + 1);
    localparam int TW = SCORE_W + PW + 1;
    localparam logic signed [TW-1:0] SMAX = TW'((1 << SCORE_W) - 1);
    localparam logic signed [TW-1:0] PEN  = TW'(MISS_PENALTY);

    logic [N_MOLES-1:0] s1_q, s2_q, sw_q, mole_clear_q;
    logic [N_MOLES-1:0] edge_m, hit_m, miss_m;
    logic [1:0]         settle_q, settle_d;
    logic               hit_pulse_q, miss_pulse_q, valid;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [COMBO_W-1:0] combo_q, combo_d;
    logic [PW-1:0]      cnt, pts;
    logic signed [TW-1:0] tmp;

    always_comb begin
        edge_m   = (EDGE_MODE != 0) ? (s2_q & ~sw_q) : (s2_q ^ sw_q);
        valid    = enable & (settle_q == 2'd3);
        hit_m    = edge_m & mole_on & {N_MOLES{valid}};
        miss_m   = edge_m & ~mole_on & {N_MOLES{valid}};
        settle_d = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
        cnt      = '0;
        for (int i = 0; i < N_MOLES; i++) cnt = cnt + PW'(hit_m[i]);
        pts      = (int'(combo_q) >= COMBO_THRESH) ? cnt << 1 : cnt;
        // Signed headroom so a penalty at score 0 goes negative before clamping.
        tmp      = $signed({{(PW + 1){1'b0}}, score_q}) + $signed({{(SCORE_W + 1){1'b0}}, pts})
                 - ((|miss_m) ? PEN : '0);
        score_d  = clear_score ? '0 : (tmp < 0) ? '0 : (tmp > SMAX) ? '1 : tmp[SCORE_W-1:0];
        combo_d  = (clear_score || (|miss_m)) ? '0 :
                   (|hit_m) ? ((combo_q == '1) ? combo_q : combo_q + 1'b1) : combo_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q         <= '0;
            s2_q         <= '0;
            sw_q         <= '0;
            settle_q     <= '0;
            mole_clear_q <= '0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            score_q      <= '0;
            combo_q      <= '0;
        end else begin
            s1_q         <= sw_in;
            s2_q         <= s1_q;
            sw_q         <= s2_q;
            settle_q     <= settle_d;
            mole_clear_q <= hit_m;
            hit_pulse_q  <= |hit_m;
            miss_pulse_q <= |miss_m;
            score_q      <= score_d;
            combo_q      <= combo_d;
        end
    end

    assign mole_clear = mole_clear_q;
    assign hit_pulse  = hit_pulse_q;
    assign miss_pulse = miss_pulse_q;
    assign score      = score_q;
    assign combo      = combo_q;
endmodule

// File: tb/tb_mole_hit_scorer.sv
// tb_mole_hit_scorer: directed checks of a default scorer and a 4-bit-score variant.
module tb_mole_hit_scorer;
    logic        clk = 1'b0, rst_n, enable, en2, clear_score, clr2;
    logic [17:0] sw_in, mole_on, mole_clear, mole_clear2;
    logic        hit_pulse, miss_pulse, hit_pulse2, miss_pulse2;
    logic [7:0]  score;
    logic [3:0]  score2;
    logic [2:0]  combo, combo2;
    int          n_chk = 0, n_fail = 0;
    int          exp_s[4] = '{1, 2, 3, 5};

    mole_hit_scorer u1 (.clk(clk), .rst_n(rst_n), .enable(enable), .clear_score(clear_score),
        .sw_in(sw_in), .mole_on(mole_on), .mole_clear(mole_clear), .hit_pulse(hit_pulse),
        .miss_pulse(miss_pulse), .score(score), .combo(combo));

    mole_hit_scorer #(.SCORE_W(4)) u2 (.clk(clk), .rst_n(rst_n), .enable(en2), .clear_score(clr2),
        .sw_in(sw_in), .mole_on(mole_on), .mole_clear(mole_clear2), .hit_pulse(hit_pulse2),
        .miss_pulse(miss_pulse2), .score(score2), .combo(combo2));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Toggle switch lanes and advance to the cycle where the resulting outputs are visible.
    task automatic ev(input logic [17:0] tog);
        sw_in = sw_in ^ tog;
        repeat (3) tick();
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; en2 = 1'b0; clear_score = 1'b0; clr2 = 1'b0;
        sw_in = '1; mole_on = '1;
        repeat (3) tick();
        chk("rst_clear", mole_clear, 0);
        chk("rst_hit", hit_pulse, 0);
        chk("rst_miss", miss_pulse, 0);
        chk("rst_score", score, 0);
        chk("rst_combo", combo, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("held_hit", hit_pulse, 0);
            chk("held_miss", miss_pulse, 0);
            chk("held_score", score, 0);
        end
        enable = 1'b0; sw_in = '0; mole_on = '0;
        repeat (5) tick();
        enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("reen_hit", hit_pulse, 0);
            chk("reen_miss", miss_pulse, 0);
        end
        mole_on = 18'd1 << 3;
        ev(18'd1 << 3);
        chk("hit_clear", mole_clear, 18'd1 << 3);
        chk("hit_pulse", hit_pulse, 1);
        chk("hit_nomiss", miss_pulse, 0);
        chk("hit_score", score, 1);
        chk("hit_combo", combo, 1);
        tick();
        chk("hit_end", hit_pulse, 0);
        chk("clear_end", mole_clear, 0);
        clear_score = 1'b1; tick(); clear_score = 1'b0;
        chk("clr_score", score, 0);
        chk("clr_combo", combo, 0);
        for (int i = 0; i < 4; i++) begin
            ev(18'd1 << 3);
            chk("combo_score", score, exp_s[i]);
            chk("combo_cnt", combo, i + 1);
            tick();
        end
        mole_on = '0;
        ev(18'd1 << 5);
        chk("miss_pulse", miss_pulse, 1);
        chk("miss_nohit", hit_pulse, 0);
        chk("miss_score", score, 4);
        chk("miss_combo", combo, 0);
        tick();
        ev(18'd1 << 5);
        chk("miss2_score", score, 3);
        tick();
        clear_score = 1'b1; tick(); clear_score = 1'b0;
        ev(18'd1 << 5);
        chk("miss0_pulse", miss_pulse, 1);
        chk("miss0_score", score, 0);
        tick();
        mole_on = 18'h003FF;
        ev(18'h003FF);
        chk("pop_clear", mole_clear, 18'h003FF);
        chk("pop_score", score, 10);
        chk("pop_combo", combo, 1);
        tick();
        mole_on = 18'h00003;
        ev(18'h00007);
        chk("mix_clear", mole_clear, 3);
        chk("mix_hit", hit_pulse, 1);
        chk("mix_miss", miss_pulse, 1);
        chk("mix_score", score, 11);
        chk("mix_combo", combo, 0);
        tick();
        enable = 1'b0; mole_on = 18'd1 << 4;
        ev(18'd1 << 4);
        chk("dis_hit", hit_pulse, 0);
        chk("dis_clear", mole_clear, 0);
        chk("dis_score", score, 11);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("dis_reen_hit", hit_pulse, 0);
            chk("dis_reen_score", score, 11);
        end
        enable = 1'b0; en2 = 1'b1; mole_on = 18'h07FFF;
        ev(18'h07FFF);
        chk("w4_score", score2, 15);
        chk("w4_hit", hit_pulse2, 1);
        chk("w4_combo", combo2, 1);
        chk("w4_u1_held", score, 11);
        tick();
        mole_on = 18'd1;
        ev(18'd1);
        chk("w4_sat_score", score2, 15);
        chk("w4_sat_combo", combo2, 2);
        tick();
        sw_in = sw_in ^ 18'd1;
        tick(); tick();
        clr2 = 1'b1; tick(); clr2 = 1'b0;
        chk("w4_clr_score", score2, 0);
        chk("w4_clr_combo", combo2, 0);
        chk("w4_clr_hit", hit_pulse2, 1);
        chk("w4_clr_mask", mole_clear2, 1);
        tick();
        ev(18'd1);
        chk("w4_pre_rst_hit", hit_pulse2, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_hit", hit_pulse2, 0);
        chk("mid_rst_mask", mole_clear2, 0);
        chk("mid_rst_score2", score2, 0);
        chk("mid_rst_score", score, 0);
        chk("mid_rst_combo2", combo2, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
